// File: rtl/barrel_scheduler.sv
// Multi-channel barrel slot scheduler: detects key edges, enforces a per-channel
// cooldown, allocates the lowest free mover slot and releases it on mover done.
module barrel_scheduler #(
  parameter int CHANNELS = 2,
  parameter int SLOTS    = 5,
  parameter int CNT_W    = 28,
  parameter int OCC_W    = $clog2(SLOTS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_game,
  input  logic                      animation,
  input  logic [CHANNELS-1:0]       key,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  input  logic [CHANNELS*SLOTS-1:0] done,
  output logic [CHANNELS*SLOTS-1:0] barrel,
  output logic [CHANNELS-1:0]       spawn,
  output logic [CHANNELS-1:0]       denied,
  output logic [CHANNELS*OCC_W-1:0] occupancy
);

  typedef enum logic [1:0] {IDLE, INTRO, RUN} state_t;

  state_t                    state_q;
  logic [CHANNELS-1:0]       key_q;
  logic [CHANNELS*CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS*SLOTS-1:0] barrel_q, barrel_d;
  logic [CHANNELS-1:0]       spawn_q, spawn_d;
  logic [CHANNELS-1:0]       denied_q, denied_d;
  logic [CHANNELS*OCC_W-1:0] occ_q, occ_d;
  logic                      run;

  function automatic logic [OCC_W-1:0] popcount(input logic [SLOTS-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SLOTS; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  // Leaving RUN clears the outputs on the very next cycle, not one cycle later.
  assign run = (state_q == RUN) && start_game;

  always_comb begin
    barrel_d = '0;
    spawn_d  = '0;
    denied_d = '0;
    occ_d    = '0;
    cnt_d    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      logic [SLOTS-1:0] cur, alloc, nxt;
      logic [CNT_W-1:0] cnt, dly, cnt_n;
      logic             found, req;
      cur   = barrel_q[c*SLOTS +: SLOTS];
      cnt   = cnt_q[c*CNT_W +: CNT_W];
      dly   = delay[c*CNT_W +: CNT_W];
      req   = key[c] & ~key_q[c] & run;
      alloc = '0;
      found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (!found && !cur[s]) begin
          alloc[s] = 1'b1;
          found    = 1'b1;
        end
      end
      if (run) begin
        cnt_n = cnt;
        if (req && (cnt == '0) && found) begin
          spawn_d[c] = 1'b1;
          cnt_n      = (dly == '0) ? '0 : dly - CNT_W'(1);
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end
        if (req && (cnt == '0) && !found) denied_d[c] = 1'b1;
        // Allocation sees pre-release occupancy; a slot freed now is reusable next cycle.
        nxt = (cur & ~done[c*SLOTS +: SLOTS]) | (spawn_d[c] ? alloc : '0);
      end else begin
        cnt_n = '0;
        nxt   = '0;
      end
      barrel_d[c*SLOTS +: SLOTS] = nxt;
      occ_d[c*OCC_W +: OCC_W]    = popcount(nxt);
      cnt_d[c*CNT_W +: CNT_W]    = cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_game) state_q <= INTRO;
        INTRO:   if (!start_game) state_q <= IDLE;
                 else if (!animation) state_q <= RUN;
        RUN:     if (!start_game) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q    <= '0;
      cnt_q    <= '0;
      barrel_q <= '0;
      spawn_q  <= '0;
      denied_q <= '0;
      occ_q    <= '0;
    end else begin
      key_q    <= key;
      cnt_q    <= cnt_d;
      barrel_q <= barrel_d;
      spawn_q  <= spawn_d;
      denied_q <= denied_d;
      occ_q    <= occ_d;
    end
  end

  assign barrel    = barrel_q;
  assign spawn     = spawn_q;
  assign denied    = denied_q;
  assign occupancy = occ_q;

endmodule

// File: doc/barrel_scheduler.md
Name: barrel_scheduler

Overview:
- Parametrised successor of the per-direction barrel controllers.
- One block manages CHANNELS independent barrel groups (e.g. horizontal and vertical), each with SLOTS mover slots.
- Per channel it provides key edge detection, runtime-programmable cooldown, lowest-free-slot allocation, slot release on mover done, and occupancy/denial reporting.
- Sits between the UART key decoder and the hor_barrel/ver_barrel movers, and drives the barrel enable bus of draw_barrel.

Parameters:
- CHANNELS, 2, number of independent barrel groups.
- SLOTS, 5, mover slots per channel.
- CNT_W, 28, cooldown counter width in clk cycles.
- OCC_W, $clog2(SLOTS+1), occupancy count width. Derived; not overridden.

Ports:
- clk  input  1  system clock (65 MHz).
- rst  input  1  asynchronous, active-low reset.
- start_game  input  1  level; game started.
- animation  input  1  level; intro animation in progress.
- key  input  CHANNELS  per-channel spawn request level, synchronous to clk.
- delay  input  CHANNELS*CNT_W  per-channel cooldown; channel c occupies bits [c*CNT_W +: CNT_W].
- done  input  CHANNELS*SLOTS  one-cycle pulse from a mover when its barrel leaves the screen; slot index = c*SLOTS+s.
- barrel  output  CHANNELS*SLOTS  slot active level; same indexing as done.
- spawn  output  CHANNELS  one-cycle pulse when a slot is allocated.
- denied  output  CHANNELS  one-cycle pulse when a request is refused because the channel is full.
- occupancy  output  CHANNELS*OCC_W  number of active slots per channel.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, FSM is in IDLE, key history is 0, all cooldown counters are 0.
- Global FSM, registered:
  - IDLE: go to INTRO when start_game=1.
  - INTRO: go to RUN when animation=0. Go to IDLE when start_game=0.
  - RUN: go to IDLE when start_game=0.
- In any state other than RUN: barrel, spawn, denied and occupancy are forced to 0 next cycle, and cooldown counters are cleared.
- Key edge: key_q is the registered copy of key, updated in every state. A request is req[c] = key[c] & ~key_q[c] & (state==RUN). A key held through entry into RUN does not spawn.
- Cooldown: cnt[c] decrements by 1 per cycle while nonzero. Load rule on an accepted request: delay[c]==0 means no cooldown; otherwise cnt[c] loads delay[c]-1.
  - Each accepted request pulses spawn[c] one cycle. The next acceptance is possible no earlier than delay[c] cycles later.
- Cycle t, if req[c] arrives while cnt[c]!=0: the request is dropped silently; no spawn, no denied pulse.
- Cycle t, if req[c] arrives with cnt[c]==0 and at least one free slot (based on barrel state at cycle t): the lowest-index free slot s is set.
  - barrel[c*SLOTS+s]=1 at t+1.
  - spawn[c]=1 for cycle t+1 only.
  - The cooldown loads.
- Cycle t, if req[c] arrives with cnt[c]==0 and all slots busy: denied[c]=1 at t+1 for one cycle. No cooldown load.
- Release: done[i]=1 at cycle t clears barrel[i] at t+1. done on an inactive slot is ignored.
- Simultaneous done and request on the same channel: allocation uses pre-release state, so a slot freed in cycle t is not reusable until t+1.
  - If the channel was full, the request is denied even though a slot is freed in the same cycle.
- occupancy[c] is the registered popcount of that channel's barrel bits, valid in the same cycle as barrel (no extra latency).
- Channels are fully independent. Simultaneous requests on different channels are all served in the same cycle.
- Reset mid-operation clears everything asynchronously. After release, the FSM restarts in IDLE.
- cnt width arithmetic: delay is unsigned CNT_W bits; the counter never underflows.

Test Plan:
- Reset and idle: rst=0 with key=2'b11, then rst=1 with start_game=0 and key toggled. Required: barrel=0, spawn=0, denied=0, occupancy=0 throughout.
- Basic spawn: start_game=1, animation=0, RUN reached, delay[0]=0, key[0] rises at cycle t. Required: barrel=10'b0000000001 at t+1, spawn[0] high exactly at t+1, occupancy[0]=1.
- Cooldown: delay[0]=4, key[0] pulses at t, t+2 and t+4. Required: spawns at t+1 and t+5 only; slots 0 and 1 set; no denied pulse.
- Full channel: delay=0, SLOTS=5, six key[1] edges. Required: slots 5..9 set in order; the sixth edge gives denied[1]=1 for one cycle; occupancy[1]=5.
- Release and reuse: with slots 0..2 active, pulse done[1]. Required: barrel[1]=0 next cycle. A new key[0] edge then allocates slot 1, not slot 3. done[1] coincident with a request while channel 0 is full gives denied[0].
- Game exit and held key: key[0]=1 held through INTRO into RUN gives no spawn. start_game drops with 3 barrels active; required: barrel=0 on the next cycle and FSM in IDLE.
